// File: rtl/stream_processor.sv
`default_nettype none
// ============================================================================
// Module      : stream_processor
// Description : Instruction-driven sequencer that steps a spiking network and
//               queues its per-step results in a credit-controlled output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_processor #(
    parameter int NUM_INP     = 8,
    parameter int NUM_OUT     = 8,
    parameter int RUN_WIDTH   = 16,
    parameter int INSTR_DEPTH = 4,
    parameter int OUT_DEPTH   = 4,
    localparam int PAYLOAD_WIDTH = (NUM_INP > RUN_WIDTH) ? NUM_INP : RUN_WIDTH,
    localparam int INSTR_WIDTH   = PAYLOAD_WIDTH + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   net_en,
    output logic                   net_clear,
    output logic [NUM_INP-1:0]     net_inp,
    input  logic [NUM_OUT-1:0]     net_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OUT-1:0]     out,
    output logic                   out_last,
    output logic                   busy
);

    localparam int c_ipw = $clog2(INSTR_DEPTH);
    localparam int c_icw = $clog2(INSTR_DEPTH + 1);
    localparam int c_opw = $clog2(OUT_DEPTH);
    localparam int c_ocw = $clog2(OUT_DEPTH + 1);

    localparam logic [c_icw-1:0]     c_instr_full = c_icw'(INSTR_DEPTH);
    localparam logic [c_ocw:0]       c_out_limit  = (c_ocw + 1)'(OUT_DEPTH);
    localparam logic [RUN_WIDTH-1:0] c_run_one    = RUN_WIDTH'(1);

    localparam logic [1:0] c_op_nop   = 2'b00;
    localparam logic [1:0] c_op_spike = 2'b01;
    localparam logic [1:0] c_op_run   = 2'b10;
    localparam logic [1:0] c_op_clear = 2'b11;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    // Instruction FIFO
    logic [INSTR_WIDTH-1:0] r_imem [INSTR_DEPTH];
    logic [c_ipw-1:0]       r_iwp;
    logic [c_ipw-1:0]       r_irp;
    logic [c_icw-1:0]       r_icnt;

    // Output FIFO: {last tag, network result}
    logic [NUM_OUT:0]       r_omem [OUT_DEPTH];
    logic [c_opw-1:0]       r_owp;
    logic [c_opw-1:0]       r_orp;
    logic [c_ocw-1:0]       r_ocnt;

    // Sequencer
    logic [1:0]             r_state;
    logic [RUN_WIDTH-1:0]   r_remaining;
    logic                   r_first;
    logic [NUM_INP-1:0]     r_pending;
    logic                   r_inflight;
    logic                   r_inflight_last;

    logic                     w_ipush;
    logic                     w_ipop;
    logic [INSTR_WIDTH-1:0]   w_head;
    logic [1:0]               w_op;
    logic [PAYLOAD_WIDTH-1:0] w_payload;
    logic [RUN_WIDTH-1:0]     w_run_count;
    logic [c_ocw:0]           w_occupancy;
    logic                     w_credit_ok;
    logic                     w_step;
    logic                     w_opush;
    logic                     w_opop;

    assign w_ipush     = instr_valid && instr_ready;
    assign w_ipop      = (r_state == c_st_idle) && (r_icnt != '0);
    assign w_head      = r_imem[r_irp];
    assign w_op        = w_head[INSTR_WIDTH-1 -: 2];
    assign w_payload   = w_head[PAYLOAD_WIDTH-1:0];
    assign w_run_count = w_payload[RUN_WIDTH-1:0];

    // Credit counts only registered state; a pop in this same cycle earns nothing.
    assign w_occupancy = {1'b0, r_ocnt} + {{c_ocw{1'b0}}, r_inflight};
    assign w_credit_ok = (w_occupancy < c_out_limit);
    assign w_step      = !rst && (r_state == c_st_run) && w_credit_ok;

    assign w_opush = r_inflight;
    assign w_opop  = out_valid && out_ready;

    assign instr_ready = (r_icnt != c_instr_full);
    assign net_en      = w_step;
    assign net_inp     = (w_step && r_first) ? r_pending : '0;
    assign net_clear   = rst || (r_state == c_st_clear);
    assign out_valid   = !rst && (r_ocnt != '0);
    assign {out_last, out} = r_omem[r_orp];
    assign busy        = !rst && ((r_state != c_st_idle) || (r_icnt != '0) ||
                                  r_inflight || (r_ocnt != '0));

    always_ff @(posedge clk) begin
        if (w_ipush) begin
            r_imem[r_iwp] <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iwp  <= '0;
            r_irp  <= '0;
            r_icnt <= '0;
        end else begin
            if (w_ipush) begin
                r_iwp <= r_iwp + 1'b1;
            end
            if (w_ipop) begin
                r_irp <= r_irp + 1'b1;
            end
            case ({w_ipush, w_ipop})
                2'b10:   r_icnt <= r_icnt + 1'b1;
                2'b01:   r_icnt <= r_icnt - 1'b1;
                default: r_icnt <= r_icnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_opush) begin
            r_omem[r_owp] <= {r_inflight_last, net_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owp  <= '0;
            r_orp  <= '0;
            r_ocnt <= '0;
        end else begin
            if (w_opush) begin
                r_owp <= r_owp + 1'b1;
            end
            if (w_opop) begin
                r_orp <= r_orp + 1'b1;
            end
            case ({w_opush, w_opop})
                2'b10:   r_ocnt <= r_ocnt + 1'b1;
                2'b01:   r_ocnt <= r_ocnt - 1'b1;
                default: r_ocnt <= r_ocnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_remaining     <= '0;
            r_first         <= 1'b0;
            r_pending       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            // Capture bookkeeping runs independently of the state so the final
            // step's result is still collected after returning to idle.
            r_inflight      <= w_step;
            r_inflight_last <= w_step && (r_remaining == c_run_one);

            case (r_state)
                c_st_idle: begin
                    if (w_ipop) begin
                        case (w_op)
                            c_op_nop: begin
                            end
                            c_op_spike: begin
                                r_pending <= r_pending | w_payload[NUM_INP-1:0];
                            end
                            c_op_run: begin
                                if (w_run_count != '0) begin
                                    r_remaining <= w_run_count;
                                    r_first     <= 1'b1;
                                    r_state     <= c_st_run;
                                end
                            end
                            c_op_clear: begin
                                r_state <= c_st_clear;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                c_st_run: begin
                    if (w_step) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_first) begin
                            r_first   <= 1'b0;
                            r_pending <= '0;
                        end
                        if (r_remaining == c_run_one) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_clear: begin
                    r_pending <= '0;
                    r_state   <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_processor
// Description : Self-checking bench for stream_processor with a network stub,
//               a vector table, directed corner sequences and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_processor;

    localparam logic [1:0] c_nop   = 2'b00;
    localparam logic [1:0] c_spike = 2'b01;
    localparam logic [1:0] c_run   = 2'b10;
    localparam logic [1:0] c_clear = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic        net_en;
    logic        net_clear;
    logic [7:0]  net_inp;
    logic [7:0]  net_out = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    int         stub_k = 0;
    bit         fixed_mode = 0;
    int         fix_base = 0;
    bit         rand_rdy = 0;
    logic [7:0] en_q[$];
    int         en_cyc[$];
    logic [8:0] pop_q[$];
    int         clr_cnt = 0;
    int         clr_cyc = 0;

    logic [8:0] exp_q[$];
    logic [7:0] model_pend;
    int         model_k;
    int         model_clears;

    typedef struct {
        logic [7:0]  spk;
        logic [15:0] cnt;
        bit          hold;
        int          stall_steps;
        int          outs;
        logic [7:0]  first_inp;
    } vec_t;
    vec_t tbl[7];

    stream_processor dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .net_en      (net_en),
        .net_clear   (net_clear),
        .net_inp     (net_inp),
        .net_out     (net_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] net_val(input int k, input logic [7:0] inp);
        logic [31:0] t;
        t = k * 59 + 92;
        return t[7:0] ^ inp;
    endfunction

    // Network stub: result appears the cycle after net_en
    always @(posedge clk) begin
        if (net_en) begin
            net_out <= fixed_mode ? 8'(8'hA1 + (stub_k - fix_base)) : net_val(stub_k, net_inp);
            stub_k  <= stub_k + 1;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (net_en) begin
            en_q.push_back(net_inp);
            en_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) pop_q.push_back({out_last, out});
        if (net_clear && !rst) begin
            clr_cnt = clr_cnt + 1;
            clr_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom % 4) != 0;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] pl);
        int t = 0;
        instr_valid = 1'b1;
        instr = {op, pl};
        while (!instr_ready && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) check("send_timeout", 1, 0);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 3000) begin
            tick();
            t++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic clear_logs();
        en_q.delete();
        en_cyc.delete();
        pop_q.delete();
        clr_cnt = 0;
    endtask

    // Reference model: the ordered list of results an accepted instruction implies
    task automatic model_apply(input logic [1:0] op, input logic [15:0] pl);
        case (op)
            c_spike: model_pend = model_pend | pl[7:0];
            c_run: begin
                for (int i = 0; i < int'(pl); i++) begin
                    exp_q.push_back({(i == int'(pl) - 1), net_val(model_k, (i == 0) ? model_pend : 8'h00)});
                    if (i == 0) model_pend = 8'h00;
                    model_k++;
                end
            end
            c_clear: begin
                model_pend = 8'h00;
                model_clears++;
            end
            default: ;
        endcase
    endtask

    initial begin
        int acc;
        int n;
        int t;
        int base;
        logic [1:0]  op;
        logic [15:0] pl;

        tbl[0] = '{8'h3C, 16'd1,  1'b0, 1,  1,  8'h3C};
        tbl[1] = '{8'h00, 16'd0,  1'b0, 0,  0,  8'h00};
        tbl[2] = '{8'h81, 16'd10, 1'b1, 4,  10, 8'h81};
        tbl[3] = '{8'h0F, 16'd4,  1'b1, 4,  4,  8'h0F};
        tbl[4] = '{8'h10, 16'd5,  1'b0, 5,  5,  8'h10};
        tbl[5] = '{8'h00, 16'd3,  1'b1, 3,  3,  8'h00};
        tbl[6] = '{8'h5A, 16'd2,  1'b0, 2,  2,  8'h5A};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        out_ready = 1'b0;

        // Two reset cycles
        @(negedge clk);
        check("rst_clear_c1", net_clear, 1);
        @(negedge clk);
        check("rst_clear_c2", net_clear, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_net_en", net_en, 0);
        check("rst_busy", busy, 0);
        check("rst_net_clear_after", net_clear, 0);

        // Two spikes merged into the first step of RUN 3
        tick();
        clear_logs();
        out_ready = 1'b1;
        fixed_mode = 1;
        fix_base = stub_k;
        send(c_spike, 16'h0005);
        send(c_spike, 16'h0030);
        send(c_run, 16'd3);
        wait_idle();
        fixed_mode = 0;
        check("run3_steps", en_q.size(), 3);
        if (en_q.size() == 3) begin
            check("run3_inp0", en_q[0], 8'h35);
            check("run3_inp1", en_q[1], 8'h00);
            check("run3_inp2", en_q[2], 8'h00);
            check("run3_consecutive", en_cyc[2] - en_cyc[0], 2);
        end
        check("run3_outs", pop_q.size(), 3);
        if (pop_q.size() == 3) begin
            check("run3_out0", pop_q[0], 9'h0A1);
            check("run3_out1", pop_q[1], 9'h0A2);
            check("run3_out2", pop_q[2], 9'h1A3);
        end

        // Vector table: single RUN per entry, optional output stall
        for (int e = 0; e < 7; e++) begin
            clear_logs();
            base = stub_k;
            out_ready = !tbl[e].hold;
            send(c_spike, {8'hC3, tbl[e].spk});
            send(c_run, tbl[e].cnt);
            tick(20);
            check($sformatf("tbl%0d_stall_steps", e), en_q.size(), tbl[e].stall_steps);
            out_ready = 1'b1;
            wait_idle();
            check($sformatf("tbl%0d_steps", e), en_q.size(), tbl[e].outs);
            check($sformatf("tbl%0d_outs", e), pop_q.size(), tbl[e].outs);
            if (tbl[e].outs > 0 && en_q.size() > 0)
                check($sformatf("tbl%0d_first_inp", e), en_q[0], tbl[e].first_inp);
            for (int i = 0; i < pop_q.size() && i < tbl[e].outs; i++)
                check($sformatf("tbl%0d_out%0d", e, i), pop_q[i],
                      {(i == tbl[e].outs - 1), net_val(base + i, (i == 0) ? tbl[e].first_inp : 8'h00)});
        end

        // Instruction FIFO backpressure during a long RUN
        clear_logs();
        out_ready = 1'b1;
        send(c_run, 16'd100);
        tick(3);
        acc = 0;
        instr = {c_nop, 16'h1234};
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (instr_ready) acc++;
            tick();
            instr_valid = (acc < 5);
        end
        check("bp_accepted_during_run", acc, 4);
        check("bp_instr_ready_low", instr_ready, 0);
        t = 0;
        while (acc < 5 && t < 300) begin
            if (instr_ready) acc++;
            tick();
            instr_valid = (acc < 5);
            t++;
        end
        instr_valid = 1'b0;
        check("bp_fifth_accepted", acc, 5);
        check("bp_run_done_before_fifth", en_q.size(), 100);
        wait_idle();
        check("bp_outs", pop_q.size(), 100);
        n = 0;
        foreach (pop_q[i]) if (pop_q[i][8]) n++;
        check("bp_last_tags", n, 1);
        if (pop_q.size() == 100) check("bp_last_on_final", pop_q[99][8], 1);

        // CLEAR discards pending spikes
        clear_logs();
        send(c_spike, 16'h00FF);
        send(c_clear, 16'hFFFF);
        send(c_run, 16'd1);
        wait_idle();
        check("clr_cycles", clr_cnt, 1);
        check("clr_steps", en_q.size(), 1);
        if (en_q.size() == 1) begin
            check("clr_inp", en_q[0], 8'h00);
            check("clr_before_step", (clr_cyc < en_cyc[0]), 1);
        end
        check("clr_outs", pop_q.size(), 1);
        if (pop_q.size() == 1) check("clr_out_last", pop_q[0][8], 1);

        // Reset during step 3 of RUN 8
        clear_logs();
        send(c_run, 16'd8);
        t = 0;
        while (en_q.size() < 2 && t < 100) begin
            tick();
            t++;
        end
        rst = 1'b1;
        n = en_q.size();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_instr_ready", instr_ready, 1);
        check("abort_net_clear", net_clear, 0);
        tick(10);
        check("abort_no_more_steps", en_q.size(), n);
        pop_q.delete();
        send(c_run, 16'd1);
        wait_idle();
        check("abort_run1_outs", pop_q.size(), 1);
        if (pop_q.size() == 1) check("abort_run1_last", pop_q[0][8], 1);

        // Random instruction stream with random output backpressure
        clear_logs();
        exp_q.delete();
        model_pend = 8'h00;
        model_k = stub_k;
        model_clears = 0;
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom % 4);
            pl = 16'($urandom);
            if (op == c_run) pl = 16'($urandom_range(0, 6));
            send(op, pl);
            model_apply(op, pl);
            tick($urandom_range(0, 2));
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        wait_idle();
        check("rand_outs", pop_q.size(), exp_q.size());
        check("rand_clears", clr_cnt, model_clears);
        for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++)
            check($sformatf("rand_out%0d", i), pop_q[i], exp_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_processor.md
STREAM_PROCESSOR -- requirements
Module: stream_processor

Interface
REQ-001 Parameter NUM_INP, default 8: network input spike-vector width.
REQ-002 Parameter NUM_OUT, default 8: network output vector width.
REQ-003 Parameter RUN_WIDTH, default 16: run-count field width.
REQ-004 Parameter INSTR_DEPTH, default 4: instruction FIFO entries (power of two, >=2).
REQ-005 Parameter OUT_DEPTH, default 4: output FIFO entries (power of two, >=2).
REQ-006 Derived: PAYLOAD_WIDTH = max(NUM_INP, RUN_WIDTH); INSTR_WIDTH = PAYLOAD_WIDTH+2; opcode = instr[INSTR_WIDTH-1:INSTR_WIDTH-2], payload = low PAYLOAD_WIDTH bits.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 instr_valid  input  1  instruction offered.
REQ-010 instr_ready  output  1  instruction FIFO can accept.
REQ-011 instr  input  INSTR_WIDTH  instruction word.
REQ-012 net_en  output  1  advance network one timestep.
REQ-013 net_clear  output  1  clear network state.
REQ-014 net_inp  output  NUM_INP  spikes applied with net_en.
REQ-015 net_out  input  NUM_OUT  network result, valid the cycle after net_en.
REQ-016 out_valid  output  1  output FIFO non-empty.
REQ-017 out_ready  input  1  consumer accepts output.
REQ-018 out  output  NUM_OUT  head output vector.
REQ-019 out_last  output  1  head entry is final step of its RUN.
REQ-020 busy  output  1  work pending anywhere in block.

Function
REQ-021 Instruction FIFO: push on instr_valid&&instr_ready; instr_ready = !full from registered count; no pass-through when full.
REQ-022 Opcodes: 00 NOP, 01 SPIKE, 10 RUN, 11 CLEAR.
REQ-023 FSM states IDLE, RUN, CLEAR; instructions popped only in IDLE, one per cycle, strictly in order.
REQ-024 IDLE, NOP: pop, stay IDLE.
REQ-025 IDLE, SPIKE: pop, pending_spk |= payload[NUM_INP-1:0], stay IDLE.
REQ-026 IDLE, RUN count 0: pop, no step, stay IDLE.
REQ-027 IDLE, RUN count N>0: pop, remaining<=N, first<=1, go RUN.
REQ-028 IDLE, CLEAR: pop, go CLEAR; CLEAR state drives net_clear=1 exactly one cycle, zeroes pending_spk, returns IDLE.
REQ-029 RUN: net_en=1 only when out_count + inflight < OUT_DEPTH (inflight = net_en of previous cycle, registered counts only; same-cycle output pop gives no credit).
REQ-030 RUN: net_inp = pending_spk on first step, 0 on later steps and whenever net_en=0; pending_spk zeroed when first step issues.
REQ-031 Each issued step decrements remaining; step issued with remaining==1 tagged last; FSM returns IDLE the next cycle.
REQ-032 Cycle after each net_en, {last tag, net_out} pushed to output FIFO; capture proceeds even if FSM has left RUN.
REQ-033 Output FIFO: out_valid = !empty; pop on out_valid&&out_ready; out/out_last show head; no entry lost or duplicated under any backpressure.
REQ-034 busy = (state!=IDLE) | instr FIFO non-empty | inflight | out_valid.
REQ-035 Max RUN count 2^RUN_WIDTH-1 with no wrap of remaining.
REQ-036 Payload bits above NUM_INP ignored for SPIKE; above RUN_WIDTH ignored for RUN; payload ignored for NOP/CLEAR.

Reset
REQ-037 rst high: both FIFOs emptied, state IDLE, remaining 0, pending_spk 0, inflight 0; net_en=0, net_inp=0, out_valid=0, busy=0; net_clear=1 during every rst cycle.
REQ-038 rst mid-RUN aborts the run; in-flight capture discarded; first cycle after rst: instr_ready=1, net_clear=0.

Verification
REQ-039 Reset: rst 2 cycles -> net_clear=1 both cycles, then instr_ready=1, out_valid=0, net_en=0, busy=0.
REQ-040 SPIKE 0x05, SPIKE 0x30, RUN 3, out_ready=1, model net_out 0xA1/0xA2/0xA3 -> net_en 3 consecutive cycles, net_inp 0x35,0x00,0x00; outputs 0xA1,0xA2,0xA3; out_last only on 0xA3.
REQ-041 out_ready=0, RUN 10 -> exactly 4 net_en pulses then net_en low; out_ready=1 resumes; 10 outputs in order, out_last only on 10th, busy falls after last pop.
REQ-042 RUN 100 in progress, 5 instructions offered back-to-back -> first 4 accepted, instr_ready=0 while 5th held, 5th accepted after RUN ends.
REQ-043 RUN 0 -> no net_en, no output; SPIKE 0xFF, CLEAR, RUN 1 -> net_clear one cycle, then net_en with net_inp=0x00.
REQ-044 rst asserted during step 3 of RUN 8 -> no further net_en, out_valid=0 after reset, subsequent RUN 1 yields exactly one output with out_last=1.
